tl_a_master_arbiter: RTL
========================

// Module: tl_a_master_arbiter
// PURPOSE
// - Shares the tile's single TileLink A channel between two masters (m0 = core, m1 = debug/test loader).
// - Uses round-robin arbitration and holds the grant for a whole multi-beat message.
// - Remaps sources so out_a_source = {idx, src[1:0]}.
// - Routes D responses back to the owning master using d_source[2].
// - Sits between the tile-level A/D ports and the L2 buffer interface, in the core clock domain.
// PARAMETERS
// - BEAT_LOG2  default 3   log2 bytes per beat (64-bit data bus)
// - MAX_SIZE   default 6   largest legal a_size (64 B, i.e. 8 beats)
// - SRC_W      default 2   per-master source width; out source = SRC_W+1 = 3
// PORTS
// - clk             in   1   core clock
// - reset           in   1   synchronous, active-high
// - mN_a_valid      in   1   per master N = 0,1: A request valid
// - mN_a_ready      out  1   A request accepted
// - mN_a_opcode     in   3   TL opcode
// - mN_a_param      in   3   TL param
// - mN_a_size       in   3   log2 bytes
// - mN_a_source     in   2   master-local source id
// - mN_a_address    in   32  byte address
// - mN_a_mask       in   8   byte mask
// - mN_a_data       in   64  write data
// - out_a_valid / out_a_ready / out_a_{opcode,param,size,source[3],address,mask,data}  out/in  merged A channel
// - out_d_valid     in   1   D response valid
// - out_d_ready     out  1   D response accepted
// - out_d_{opcode[3],param[2],size[3],source[3],sink[2],data[64]}  in  D response fields
// - mN_d_valid      out  1   per master N = 0,1: routed D response valid
// - mN_d_ready      in   1   D response accepted
// - mN_d_{opcode,param,size,source[2],sink,data}  out  D fields; source = out_d_source[1:0]
// BEHAVIOUR
// - Reset: locked=0, beats_left=0, rr_ptr=0 (m0 favoured); all ready/valid outputs 0 while reset=1.
// - Grant, unlocked: combinational, zero latency.
//   - Both valid: grant the master named by rr_ptr.
//   - One valid: grant that master.
//   - out_a_* = granted master's fields, with source rewritten.
// - Grant, locked: grant stays fixed to lock_idx; the other master's a_ready is 0.
// - Ready: mN_a_ready = out_a_ready & grant==N. No buffering; fire = out_a_valid & out_a_ready.
// - Data opcodes (0 PutFull, 1 PutPartial, 2 Arith, 3 Logical):
//   - beats = size>BEAT_LOG2 ? 1<<(size-BEAT_LOG2) : 1.
//   - All other opcodes are 1 beat.
// - First-beat fire of a message with beats>1: locked<=1, lock_idx<=grant, beats_left<=beats-1.
// - Each later fire decrements beats_left. Fire with beats_left==1 clears locked.
// - rr_ptr <= ~grant on the fire of a message's last beat (single-beat fire counts as last).
// - Locked master dropping valid mid-burst: grant is held and out_a_valid=0; no switch.
// - D routing: idx = out_d_source[2].
//   - m_idx_d_valid = out_d_valid; the other master's d_valid = 0.
//   - out_d_ready = m_idx_d_ready.
//   - Per-beat, stateless, 0 latency. D runs independently of A (concurrent A fire and D beat allowed).
// - size > MAX_SIZE: forwarded unchanged; beat count saturates at 1<<(MAX_SIZE-BEAT_LOG2).
// - Reset mid-burst: lock and counters are cleared; the partial message is abandoned.
// STRUCTURE
// - Shared package tl_pkg: TL opcode constants, BEAT_LOG2, tl_a_t / tl_d_t field structs, function tl_beats(opcode,size).
// - One sub-module: tl_rr_arb2 (2-way round-robin with lock input, grant output). Everything else stays inline.
// TESTING
// - Both valid, Get size 3, out_a_ready=1:
//   - cyc0: m0 fires with out_a_source=3'b0ss.
//   - cyc1: m1 fires with 3'b1ss.
//   - cyc2: m0 again (alternation).
// - m0 PutFull size 6 (8 beats) with m1 Get pending: m1_a_ready=0 for all 8 beats; m1 fires on the cycle after m0's beat 8.
// - out_a_ready toggling 1,0,1 during a 4-beat m1 burst: grant never moves; beats_left decrements only on fire.
// - out_d_source=3'b110, m1_d_ready=0 then 1:
//   - m1_d_valid=1, m1_d_source=2'b10, m0_d_valid=0.
//   - out_d_ready tracks m1_d_ready.
// - reset=1 asserted after beat 3 of 8: next cycle locked=0 and all valids 0; after release, m1's pending Get wins immediately when m0 is idle.
// - Concurrent m0 A fire and D beat to m1 in the same cycle: both complete with no stall.

Source files
------------

// File: rtl/tl_a_master_arbiter_pkg.sv
// tl_a_master_arbiter_pkg: TileLink A/D field structs, opcodes and beat-count helper
package tl_a_master_arbiter_pkg;

    localparam int TL_BEAT_LOG2 = 3;
    localparam int TL_MAX_SIZE  = 6;

    localparam logic [2:0] PUT_FULL    = 3'd0;
    localparam logic [2:0] PUT_PARTIAL = 3'd1;
    localparam logic [2:0] ARITH       = 3'd2;
    localparam logic [2:0] LOGICAL     = 3'd3;

    typedef struct packed {
        logic [2:0]  opcode;
        logic [2:0]  param;
        logic [2:0]  size;
        logic [31:0] address;
        logic [7:0]  mask;
        logic [63:0] data;
    } tl_a_t;

    typedef struct packed {
        logic [2:0]  opcode;
        logic [1:0]  param;
        logic [2:0]  size;
        logic [1:0]  sink;
        logic [63:0] data;
    } tl_d_t;

    // Oversized requests saturate at the largest legal burst length.
    function automatic logic [7:0] tl_beats(input logic [2:0] opcode, input logic [2:0] size,
                                            input int beat_log2, input int max_size);
        int s;
        s = (int'(size) > max_size) ? max_size : int'(size);
        return (opcode inside {PUT_FULL, PUT_PARTIAL, ARITH, LOGICAL} && s > beat_log2) ?
               8'(1 << (s - beat_log2)) : 8'd1;
    endfunction

endpackage

// File: rtl/tl_a_master_arbiter_rr_arb2.sv
// tl_a_master_arbiter_rr_arb2: 2-way round-robin grant with lock override
module tl_a_master_arbiter_rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_i,
    input  logic       lock_i,
    input  logic       lock_idx_i,
    input  logic       last_i,
    output logic       gnt_o
);

    logic rr_q, rr_d;

    assign gnt_o = lock_i ? lock_idx_i : (req_i == 2'b11 ? rr_q : req_i[1]);
    assign rr_d  = last_i ? ~gnt_o : rr_q;

    always_ff @(posedge clk) begin
        if (reset) rr_q <= 1'b0;
        else       rr_q <= rr_d;
    end

endmodule

// File: rtl/tl_a_master_arbiter.sv
// tl_a_master_arbiter: shares one TileLink A channel between two masters and routes D back
module tl_a_master_arbiter
    import tl_a_master_arbiter_pkg::*;
#(
    parameter int BEAT_LOG2 = TL_BEAT_LOG2,
    parameter int MAX_SIZE  = TL_MAX_SIZE,
    parameter int SRC_W     = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             m0_a_valid_i,
    output logic             m0_a_ready_o,
    input  logic [2:0]       m0_a_opcode_i,
    input  logic [2:0]       m0_a_param_i,
    input  logic [2:0]       m0_a_size_i,
    input  logic [SRC_W-1:0] m0_a_source_i,
    input  logic [31:0]      m0_a_address_i,
    input  logic [7:0]       m0_a_mask_i,
    input  logic [63:0]      m0_a_data_i,
    input  logic             m1_a_valid_i,
    output logic             m1_a_ready_o,
    input  logic [2:0]       m1_a_opcode_i,
    input  logic [2:0]       m1_a_param_i,
    input  logic [2:0]       m1_a_size_i,
    input  logic [SRC_W-1:0] m1_a_source_i,
    input  logic [31:0]      m1_a_address_i,
    input  logic [7:0]       m1_a_mask_i,
    input  logic [63:0]      m1_a_data_i,
    output logic             out_a_valid_o,
    input  logic             out_a_ready_i,
    output logic [2:0]       out_a_opcode_o,
    output logic [2:0]       out_a_param_o,
    output logic [2:0]       out_a_size_o,
    output logic [SRC_W:0]   out_a_source_o,
    output logic [31:0]      out_a_address_o,
    output logic [7:0]       out_a_mask_o,
    output logic [63:0]      out_a_data_o,
    input  logic             out_d_valid_i,
    output logic             out_d_ready_o,
    input  logic [2:0]       out_d_opcode_i,
    input  logic [1:0]       out_d_param_i,
    input  logic [2:0]       out_d_size_i,
    input  logic [SRC_W:0]   out_d_source_i,
    input  logic [1:0]       out_d_sink_i,
    input  logic [63:0]      out_d_data_i,
    output logic             m0_d_valid_o,
    input  logic             m0_d_ready_i,
    output logic [2:0]       m0_d_opcode_o,
    output logic [1:0]       m0_d_param_o,
    output logic [2:0]       m0_d_size_o,
    output logic [SRC_W-1:0] m0_d_source_o,
    output logic [1:0]       m0_d_sink_o,
    output logic [63:0]      m0_d_data_o,
    output logic             m1_d_valid_o,
    input  logic             m1_d_ready_i,
    output logic [2:0]       m1_d_opcode_o,
    output logic [1:0]       m1_d_param_o,
    output logic [2:0]       m1_d_size_o,
    output logic [SRC_W-1:0] m1_d_source_o,
    output logic [1:0]       m1_d_sink_o,
    output logic [63:0]      m1_d_data_o
);

    tl_a_t            a0, a1, a_sel;
    tl_d_t            d_in;
    logic [SRC_W-1:0] src_sel;
    logic [7:0]       beats, left_q, left_d;
    logic             gnt, fire, last, d_idx;
    logic             locked_q, locked_d, lock_idx_q, lock_idx_d;

    assign a0   = {m0_a_opcode_i, m0_a_param_i, m0_a_size_i, m0_a_address_i, m0_a_mask_i, m0_a_data_i};
    assign a1   = {m1_a_opcode_i, m1_a_param_i, m1_a_size_i, m1_a_address_i, m1_a_mask_i, m1_a_data_i};
    assign d_in = {out_d_opcode_i, out_d_param_i, out_d_size_i, out_d_sink_i, out_d_data_i};

    tl_a_master_arbiter_rr_arb2 u_arb (
        .clk       (clk),
        .reset     (reset),
        .req_i     ({m1_a_valid_i, m0_a_valid_i}),
        .lock_i    (locked_q),
        .lock_idx_i(lock_idx_q),
        .last_i    (last),
        .gnt_o     (gnt)
    );

    // Burst lock: counts the remaining beats of a multi-beat message after its first fire.
    always_comb begin
        a_sel         = gnt ? a1 : a0;
        src_sel       = gnt ? m1_a_source_i : m0_a_source_i;
        beats         = tl_beats(a_sel.opcode, a_sel.size, BEAT_LOG2, MAX_SIZE);
        out_a_valid_o = ~reset & (gnt ? m1_a_valid_i : m0_a_valid_i);
        fire          = out_a_valid_o & out_a_ready_i;
        last          = fire & (locked_q ? left_q == 8'd1 : beats == 8'd1);
        locked_d      = locked_q;
        lock_idx_d    = lock_idx_q;
        left_d        = left_q;
        if (fire && !locked_q && beats != 8'd1) begin
            locked_d   = 1'b1;
            lock_idx_d = gnt;
            left_d     = beats - 8'd1;
        end else if (fire && locked_q) begin
            left_d   = left_q - 8'd1;
            locked_d = left_q != 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            locked_q   <= 1'b0;
            lock_idx_q <= 1'b0;
            left_q     <= 8'd0;
        end else begin
            locked_q   <= locked_d;
            lock_idx_q <= lock_idx_d;
            left_q     <= left_d;
        end
    end

    assign m0_a_ready_o    = ~reset & out_a_ready_i & ~gnt;
    assign m1_a_ready_o    = ~reset & out_a_ready_i & gnt;
    assign out_a_opcode_o  = a_sel.opcode;
    assign out_a_param_o   = a_sel.param;
    assign out_a_size_o    = a_sel.size;
    assign out_a_source_o  = {gnt, src_sel};
    assign out_a_address_o = a_sel.address;
    assign out_a_mask_o    = a_sel.mask;
    assign out_a_data_o    = a_sel.data;

    assign d_idx         = out_d_source_i[SRC_W];
    assign m0_d_valid_o  = ~reset & out_d_valid_i & ~d_idx;
    assign m1_d_valid_o  = ~reset & out_d_valid_i & d_idx;
    assign out_d_ready_o = ~reset & (d_idx ? m1_d_ready_i : m0_d_ready_i);

    assign m0_d_opcode_o = d_in.opcode;
    assign m0_d_param_o  = d_in.param;
    assign m0_d_size_o   = d_in.size;
    assign m0_d_source_o = out_d_source_i[SRC_W-1:0];
    assign m0_d_sink_o   = d_in.sink;
    assign m0_d_data_o   = d_in.data;
    assign m1_d_opcode_o = d_in.opcode;
    assign m1_d_param_o  = d_in.param;
    assign m1_d_size_o   = d_in.size;
    assign m1_d_source_o = out_d_source_i[SRC_W-1:0];
    assign m1_d_sink_o   = d_in.sink;
    assign m1_d_data_o   = d_in.data;

endmodule
